// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the counter-width helper.
package serial_sub_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // The counter must hold 0..WIDTH-1 with one spare bit of headroom.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: x - y - bi, giving the difference bit and the
// borrow-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor d = a - b - bin with valid/ready on both sides.
// Define SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
`ifdef SUB_OVF_EN
    output logic             ovf,
`endif
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_diff;
    logic             bit_bo;

    full_subtractor u_fs (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bi   (brw_q),
        .diff (bit_diff),
        .bo   (bit_bo)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // LSB first: after WIDTH shifts the first bit lands in diff_q[0].
                diff_d = {bit_diff, diff_q[WIDTH-1:1]};
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                brw_d  = bit_bo;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign d         = diff_q;
    assign bout      = brw_q;

`ifdef SUB_OVF_EN
    // Operand MSBs are shifted away, so keep copies taken at capture.
    logic a_msb_q;
    logic b_msb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (state_q == ST_IDLE && in_valid) begin
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
        end
    end

    assign ovf = out_valid & (a_msb_q ^ b_msb_q) & (a_msb_q ^ diff_q[WIDTH-1]);
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4); define SUB_OVF_EN to also
// exercise the overflow output.
`timescale 1ns/1ps
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
`ifdef SUB_OVF_EN
    logic             ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
`ifdef SUB_OVF_EN
        .ovf       (ovf),
`endif
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one operand set while in_ready is high; returns at the negedge after capture.
    task automatic start_job(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                             input logic binv);
        int waited;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_before_start", in_ready, 1);
        a        = av;
        b        = bv;
        bin      = binv;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid rises, bounded; returns at a negedge.
    task automatic wait_done(input string tag, output int edges);
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        check({tag, "_done_seen"}, out_valid, 1);
    endtask

    task automatic accept_result(input string tag, input logic [WIDTH-1:0] exp_d,
                                 input logic exp_b);
        check({tag, "_d"}, d, exp_d);
        check({tag, "_bout"}, bout, exp_b);
        check({tag, "_in_ready_done"}, in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_in_ready_idle"}, in_ready, 1);
        check({tag, "_out_valid_idle"}, out_valid, 0);
        check({tag, "_d_held_idle"}, d, exp_d);
    endtask

    initial begin
        int edges;
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_d", d, 0);
        check("rst_bout", bout, 0);
`ifdef SUB_OVF_EN
        check("rst_ovf", ovf, 0);
`endif

        // 9 - 3 = 6; out_valid follows the 4th edge after capture.
        start_job(4'd9, 4'd3, 1'b0);
        check("shift_in_ready", in_ready, 0);
        check("shift_out_valid", out_valid, 0);
        wait_done("t93", edges);
        check("t93_latency", edges, 4);
        accept_result("t93", 4'h6, 1'b0);

        start_job(4'd3, 4'd9, 1'b0);
        wait_done("t39", edges);
        accept_result("t39", 4'hA, 1'b1);

        start_job(4'd0, 4'd0, 1'b1);
        wait_done("t00b", edges);
        accept_result("t00b", 4'hF, 1'b1);

        // Back-pressure: result must hold while out_ready stays low.
        start_job(4'd9, 4'd3, 1'b0);
        wait_done("hold", edges);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_d", d, 4'h6);
            check("hold_bout", bout, 0);
            check("hold_in_ready", in_ready, 0);
        end
        accept_result("hold", 4'h6, 1'b0);

        // A stray in_valid during SHIFT must not disturb the running job.
        start_job(4'd9, 4'd3, 1'b0);
        @(posedge clk);
        @(negedge clk);
        a        = 4'd5;
        b        = 4'd1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done("pulse", edges);
        accept_result("pulse", 4'h6, 1'b0);

`ifdef SUB_OVF_EN
        start_job(4'h7, 4'hF, 1'b0);
        wait_done("ovf1", edges);
        check("ovf1_ovf", ovf, 1);
        accept_result("ovf1", 4'h8, 1'b1);
        check("ovf1_ovf_idle", ovf, 0);

        start_job(4'h2, 4'h1, 1'b0);
        wait_done("ovf0", edges);
        check("ovf0_ovf", ovf, 0);
        accept_result("ovf0", 4'h1, 1'b0);
`endif

        // Reset on the 2nd SHIFT edge aborts the job.
        start_job(4'd3, 4'd9, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_d", d, 0);
        check("abort_bout", bout, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_result", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
